// File: rtl/regj_seq.sv
// regj_seq -- sequencer/arbiter for the 12-bit J register.
//
// Shares J between three requesters and drives J's function code and data:
//   fetch   (inc_req/inc_gnt)  : J <= J + 1            (j_f = 001)
//   branch  (ld_req/ld_gnt)    : J <= ld_addr          (j_f = 010)
//   digits  (dig_*)            : insert octal field k  (j_f = 1kk), MS digit first
// All J ops and gnt/done/abort pulses are registered: decided from inputs in
// cycle N and presented together in cycle N+1.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   inc_req / inc_gnt     increment request (level) / one-cycle grant pulse
//   ld_req / ld_addr      load request (level) / value sampled when ld wins
//   ld_gnt                one-cycle load grant pulse
//   dig_start             pulse: begin a 4-digit assembly
//   dig_valid / dig_val   digit handshake valid / octal digit
//   dig_ready             digit accepted when dig_valid & dig_ready
//   dig_done / dig_abort  pulse with the 4th digit op / assembly cancelled
//   busy                  high while assembling digits
//   j_f / j_in            J function code / J data input (registered)
//
// Parameters:
//   LD_BURST        consecutive ld grants tolerated while inc is waiting (1..15)
//   TIMEOUT_CYCLES  idle digit cycles before abort (1..255), used only when
//                   REGJ_SEQ_TIMEOUT_EN is defined
//
// Optional feature: define REGJ_SEQ_TIMEOUT_EN to abort a stalled digit
// assembly. Without it the assembly waits indefinitely for digits or ld_req.

module regj_seq #(
    parameter int unsigned LD_BURST       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_req,
    output logic        inc_gnt,
    input  logic        ld_req,
    input  logic [11:0] ld_addr,
    output logic        ld_gnt,
    input  logic        dig_start,
    input  logic        dig_valid,
    input  logic [2:0]  dig_val,
    output logic        dig_ready,
    output logic        dig_done,
    output logic        dig_abort,
    output logic        busy,
    output logic [2:0]  j_f,
    output logic [11:0] j_in
);

    if (LD_BURST < 1 || LD_BURST > 15) begin : g_bad_ld_burst
        $error("regj_seq: LD_BURST out of range 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("regj_seq: TIMEOUT_CYCLES out of range 1..255");
    end

    localparam logic [3:0] BURST_MAX = 4'(LD_BURST);

    typedef enum logic {IDLE, DIG} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  burst_q, burst_d;
    logic [2:0]  j_f_d;
    logic [11:0] j_in_d;
    logic        inc_gnt_d, ld_gnt_d, dig_done_d, dig_abort_d;
    logic        ld_ok, inc_ok;
    logic [11:0] ins_val;

`ifdef REGJ_SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q, tmo_d;
`endif

    // A requester is ineligible in the cycle its own grant is visible.
    assign ld_ok     = ld_req & ~ld_gnt;
    assign inc_ok    = inc_req & ~inc_gnt;
    assign busy      = (state_q == DIG);
    assign dig_ready = busy & ~ld_req;

    always_comb begin
        ins_val = '0;
        case (idx_q)
            2'd0: ins_val = {9'b0, dig_val};
            2'd1: ins_val = {6'b0, dig_val, 3'b0};
            2'd2: ins_val = {3'b0, dig_val, 6'b0};
            2'd3: ins_val = {dig_val, 9'b0};
            default: ins_val = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        burst_d     = burst_q;
        j_f_d       = 3'b000;
        j_in_d      = '0;
        inc_gnt_d   = 1'b0;
        ld_gnt_d    = 1'b0;
        dig_done_d  = 1'b0;
        dig_abort_d = 1'b0;
`ifdef REGJ_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (burst_q == BURST_MAX && inc_ok) begin
                    inc_gnt_d = 1'b1;
                    j_f_d     = 3'b001;
                    burst_d   = '0;
                end else if (ld_req) begin
                    // A masked ld still holds priority this cycle, so the slot
                    // stays empty and inc only gets in via the burst override.
                    if (ld_ok) begin
                        ld_gnt_d = 1'b1;
                        j_f_d    = 3'b010;
                        j_in_d   = ld_addr;
                        if (inc_req && burst_q != BURST_MAX)
                            burst_d = burst_q + 4'd1;
                    end
                end else if (dig_start) begin
                    state_d = DIG;
                    idx_d   = 2'd3;
`ifdef REGJ_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else if (inc_ok) begin
                    inc_gnt_d = 1'b1;
                    j_f_d     = 3'b001;
                    burst_d   = '0;
                end
            end
            DIG: begin
                if (ld_ok) begin
                    ld_gnt_d    = 1'b1;
                    dig_abort_d = 1'b1;
                    j_f_d       = 3'b010;
                    j_in_d      = ld_addr;
                    state_d     = IDLE;
                    idx_d       = 2'd3;
                end else if (dig_valid && dig_ready) begin
                    j_f_d  = {1'b1, idx_q};
                    j_in_d = ins_val;
`ifdef REGJ_SEQ_TIMEOUT_EN
                    tmo_d  = '0;
`endif
                    if (idx_q == 2'd0) begin
                        dig_done_d = 1'b1;
                        state_d    = IDLE;
                        idx_d      = 2'd3;
                    end else begin
                        idx_d = idx_q - 2'd1;
                    end
                end
`ifdef REGJ_SEQ_TIMEOUT_EN
                else if (tmo_q == TO_LAST) begin
                    dig_abort_d = 1'b1;
                    state_d     = IDLE;
                    idx_d       = 2'd3;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
        endcase
        if (!inc_req)
            burst_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 2'd3;
            burst_q   <= '0;
            j_f       <= 3'b000;
            j_in      <= '0;
            inc_gnt   <= 1'b0;
            ld_gnt    <= 1'b0;
            dig_done  <= 1'b0;
            dig_abort <= 1'b0;
`ifdef REGJ_SEQ_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            burst_q   <= burst_d;
            j_f       <= j_f_d;
            j_in      <= j_in_d;
            inc_gnt   <= inc_gnt_d;
            ld_gnt    <= ld_gnt_d;
            dig_done  <= dig_done_d;
            dig_abort <= dig_abort_d;
`ifdef REGJ_SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

endmodule
